// File: rtl/multiport_reg_file_if.sv
// Port bundle of the multi-port register file: two write ports, reserve request,
// N_RD bypassed read ports, debug read and the full scoreboard vector.
interface multiport_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  logic                     en;
  logic                     w0_en;
  logic [ADDR_W-1:0]        w0_addr;
  logic [DATA_W-1:0]        w0_data;
  logic                     w1_en;
  logic [ADDR_W-1:0]        w1_addr;
  logic [DATA_W-1:0]        w1_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [N_RD*ADDR_W-1:0]   req_rd;
  logic [N_RD*DATA_W-1:0]   data_rd;
  logic [N_RD-1:0]          busy_rd;
  logic [ADDR_W-1:0]        req_dbg;
  logic [DATA_W-1:0]        data_dbg;
  logic [(1<<ADDR_W)-1:0]   busy_all;

  modport master (
    output en, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           rsv_en, rsv_addr, req_rd, req_dbg,
    input  data_rd, busy_rd, data_dbg, busy_all
  );

  modport slave (
    input  en, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           rsv_en, rsv_addr, req_rd, req_dbg,
    output data_rd, busy_rd, data_dbg, busy_all
  );
endinterface

// File: rtl/multiport_reg_file.sv
// Register file with two write ports, write-through bypassed read lanes and a
// per-register pending-write scoreboard; register 0 reads as zero and never goes busy.
module multiport_reg_file_rd_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  input  logic              w0_en_i,
  input  logic [ADDR_W-1:0] w0_addr_i,
  input  logic [DATA_W-1:0] w0_data_i,
  input  logic              w1_en_i,
  input  logic [ADDR_W-1:0] w1_addr_i,
  input  logic [DATA_W-1:0] w1_data_i,
  input  logic [DATA_W-1:0] stored_data_i,
  input  logic              stored_busy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);
  logic hit0, hit1, zero;

  assign zero = (addr_i == '0);
  assign hit0 = en_i & w0_en_i & (w0_addr_i == addr_i);
  assign hit1 = en_i & w1_en_i & (w1_addr_i == addr_i);

  // Port 1 outranks port 0, matching commit order.
  always_comb begin
    data_o = stored_data_i;
    busy_o = stored_busy_i;
    if (zero) begin
      data_o = '0;
      busy_o = 1'b0;
    end else if (hit1) begin
      data_o = w1_data_i;
      busy_o = 1'b0;
    end else if (hit0) begin
      data_o = w0_data_i;
      busy_o = 1'b0;
    end
  end
endmodule

module multiport_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  multiport_reg_file_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        w0_ok, w1_ok;
  logic [N_RD-1:0][DATA_W-1:0] rd_data;
  logic [N_RD-1:0]             rd_busy;

  assign w0_ok = bus.en & bus.w0_en & (bus.w0_addr != '0);
  assign w1_ok = bus.en & bus.w1_en & (bus.w1_addr != '0);

  // Reservation is applied after the write release so a same-cycle set wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_ok) begin
      regs_d[bus.w0_addr] = bus.w0_data;
      busy_d[bus.w0_addr] = 1'b0;
    end
    if (w1_ok) begin
      regs_d[bus.w1_addr] = bus.w1_data;
      busy_d[bus.w1_addr] = 1'b0;
    end
    if (bus.en && bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.req_rd[i*ADDR_W +: ADDR_W];

    multiport_reg_file_rd_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .addr_i        (addr),
      .en_i          (bus.en),
      .w0_en_i       (bus.w0_en),
      .w0_addr_i     (bus.w0_addr),
      .w0_data_i     (bus.w0_data),
      .w1_en_i       (bus.w1_en),
      .w1_addr_i     (bus.w1_addr),
      .w1_data_i     (bus.w1_data),
      .stored_data_i (regs_q[addr]),
      .stored_busy_i (busy_q[addr]),
      .data_o        (rd_data[i]),
      .busy_o        (rd_busy[i])
    );
  end

  assign bus.data_rd  = rd_data;
  assign bus.busy_rd  = rd_busy;
  assign bus.data_dbg = regs_q[bus.req_dbg];
  assign bus.busy_all = busy_q;
endmodule

// File: tb/tb_multiport_reg_file.sv
// Self-checking bench for multiport_reg_file: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_multiport_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREG = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk = 0;
  int   err = 0;

  logic [DW-1:0] mem  [NREG];
  logic          busy [NREG];

  multiport_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus ();

  multiport_reg_file #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) begin
      mem[k]  = '0;
      busy[k] = 1'b0;
    end
  endfunction

  // Architectural rules: w1 beats w0, reservation beats release, x0 immutable.
  function automatic void model_commit();
    if (!bus.en) return;
    if (bus.w0_en && bus.w0_addr != 0) begin mem[bus.w0_addr] = bus.w0_data; busy[bus.w0_addr] = 1'b0; end
    if (bus.w1_en && bus.w1_addr != 0) begin mem[bus.w1_addr] = bus.w1_data; busy[bus.w1_addr] = 1'b0; end
    if (bus.rsv_en && bus.rsv_addr != 0) busy[bus.rsv_addr] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.en && bus.w1_en && bus.w1_addr == a) return bus.w1_data;
    if (bus.en && bus.w0_en && bus.w0_addr == a) return bus.w0_data;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (bus.en && ((bus.w0_en && bus.w0_addr == a) || (bus.w1_en && bus.w1_addr == a))) return 1'b0;
    return busy[a];
  endfunction

  function automatic logic [NREG-1:0] exp_busy_all();
    logic [NREG-1:0] v;
    for (int k = 0; k < NREG; k++) v[k] = busy[k];
    return v;
  endfunction

  task automatic idle();
    bus.en = 1'b1;
    bus.w0_en = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.req_rd = '0; bus.req_dbg = '0;
  endtask

  // Commit at the rising edge, then leave the bench 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    #1;
    chk++; if (bus.data_dbg !== '0 || bus.data_rd !== '0 || bus.busy_rd !== '0 || bus.busy_all !== '0) begin
      err++; $display("FAIL reset_hold got dbg=%h rd=%h brd=%b ball=%h want 0", bus.data_dbg, bus.data_rd, bus.busy_rd, bus.busy_all);
    end
    #11 rst_n = 1'b1;
    cycle();
    bus.w0_en = 1'b1; bus.w0_addr = 5; bus.w0_data = 32'h1234;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5;
    cycle();
    idle(); bus.req_dbg = 5; bus.req_rd = {5'd0, 5'd5};
    #1;
    chk++; if (bus.data_dbg !== 32'h1234 || bus.busy_all[5] !== 1'b1) begin
      err++; $display("FAIL reset_preload got dbg=%h busy5=%b want 00001234 1", bus.data_dbg, bus.busy_all[5]);
    end
    #2 rst_n = 1'b0; model_reset();
    #1;
    chk++; if (bus.data_dbg !== '0 || bus.data_rd[DW-1:0] !== '0 || bus.busy_all !== '0 || bus.busy_rd !== '0) begin
      err++; $display("FAIL reset_async got dbg=%h rd0=%h ball=%h brd=%b want 0", bus.data_dbg, bus.data_rd[DW-1:0], bus.busy_all, bus.busy_rd);
    end
    #1 rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_bypass();
    idle();
    bus.w0_en = 1'b1; bus.w0_addr = 7; bus.w0_data = 32'hAAAA_0001;
    bus.req_rd = {5'd0, 5'd7}; bus.req_dbg = 7;
    #1;
    chk++; if (bus.data_rd[DW-1:0] !== 32'hAAAA_0001) begin
      err++; $display("FAIL bypass_rd got %h want aaaa0001", bus.data_rd[DW-1:0]);
    end
    chk++; if (bus.data_dbg !== 32'h0) begin
      err++; $display("FAIL bypass_dbg_pre got %h want 0", bus.data_dbg);
    end
    cycle();
    idle(); bus.req_dbg = 7;
    #1;
    chk++; if (bus.data_dbg !== 32'hAAAA_0001) begin
      err++; $display("FAIL bypass_dbg_post got %h want aaaa0001", bus.data_dbg);
    end
  endtask

  task automatic test_dual_write();
    idle();
    bus.w0_en = 1'b1; bus.w0_addr = 9; bus.w0_data = 32'h11;
    bus.w1_en = 1'b1; bus.w1_addr = 9; bus.w1_data = 32'h22;
    bus.req_rd = {5'd9, 5'd9};
    #1;
    chk++; if (bus.data_rd !== {32'h22, 32'h22}) begin
      err++; $display("FAIL dual_bypass got %h want 0000002200000022", bus.data_rd);
    end
    cycle();
    idle(); bus.req_dbg = 9;
    #1;
    chk++; if (bus.data_dbg !== 32'h22) begin
      err++; $display("FAIL dual_commit got %h want 00000022", bus.data_dbg);
    end
  endtask

  task automatic test_zero();
    idle();
    bus.w0_en = 1'b1; bus.w0_addr = 0; bus.w0_data = 32'hFFFF_FFFF;
    bus.w1_en = 1'b1; bus.w1_addr = 0; bus.w1_data = 32'hDEAD_BEEF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 0;
    bus.req_rd = '0;
    #1;
    chk++; if (bus.data_rd !== '0 || bus.busy_rd !== '0) begin
      err++; $display("FAIL zero_bypass got rd=%h brd=%b want 0", bus.data_rd, bus.busy_rd);
    end
    cycle();
    idle();
    #1;
    chk++; if (bus.data_dbg !== '0 || bus.busy_all[0] !== 1'b0 || bus.data_rd !== '0) begin
      err++; $display("FAIL zero_commit got dbg=%h b0=%b rd=%h want 0", bus.data_dbg, bus.busy_all[0], bus.data_rd);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 3; bus.req_rd = {5'd0, 5'd3};
    #1;
    chk++; if (bus.busy_rd[0] !== 1'b0) begin
      err++; $display("FAIL sb_rsv_same_cycle got %b want 0", bus.busy_rd[0]);
    end
    cycle();
    idle(); bus.req_rd = {5'd0, 5'd3};
    #1;
    chk++; if (bus.busy_rd[0] !== 1'b1) begin
      err++; $display("FAIL sb_rsv_next got %b want 1", bus.busy_rd[0]);
    end
    bus.w0_en = 1'b1; bus.w0_addr = 3; bus.w0_data = 32'h55;
    bus.rsv_en = 1'b1; bus.rsv_addr = 3;
    #1;
    chk++; if (bus.busy_rd[0] !== 1'b0 || bus.data_rd[DW-1:0] !== 32'h55) begin
      err++; $display("FAIL sb_wr_rsv got busy=%b data=%h want 0 00000055", bus.busy_rd[0], bus.data_rd[DW-1:0]);
    end
    cycle();
    idle(); bus.req_rd = {5'd0, 5'd3}; bus.req_dbg = 3;
    #1;
    chk++; if (bus.busy_rd[0] !== 1'b1 || bus.data_dbg !== 32'h55) begin
      err++; $display("FAIL sb_set_wins got busy=%b dbg=%h want 1 00000055", bus.busy_rd[0], bus.data_dbg);
    end
    bus.rsv_en = 1'b1; bus.rsv_addr = 3;
    cycle();
    idle(); bus.w1_en = 1'b1; bus.w1_addr = 3; bus.w1_data = 32'h66;
    cycle();
    idle(); bus.req_rd = {5'd3, 5'd0};
    #1;
    chk++; if (bus.busy_rd[1] !== 1'b0 || bus.busy_all[3] !== 1'b0) begin
      err++; $display("FAIL sb_single_release got brd1=%b ball3=%b want 0 0", bus.busy_rd[1], bus.busy_all[3]);
    end
  endtask

  task automatic test_en_low();
    logic [NREG-1:0] ball_before;
    idle();
    bus.w0_en = 1'b1; bus.w0_addr = 4; bus.w0_data = 32'h77;
    cycle();
    idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 8;
    cycle();
    idle();
    #1 ball_before = bus.busy_all;
    bus.en = 1'b0;
    bus.w0_en = 1'b1; bus.w0_addr = 4; bus.w0_data = 32'h99;
    bus.w1_en = 1'b1; bus.w1_addr = 8; bus.w1_data = 32'h12;
    bus.rsv_en = 1'b1; bus.rsv_addr = 6;
    bus.req_rd = {5'd8, 5'd4}; bus.req_dbg = 4;
    #1;
    chk++; if (bus.data_rd[DW-1:0] !== 32'h77 || bus.busy_rd[1] !== 1'b1) begin
      err++; $display("FAIL en0_no_bypass got rd0=%h brd1=%b want 00000077 1", bus.data_rd[DW-1:0], bus.busy_rd[1]);
    end
    cycle();
    #1;
    chk++; if (bus.data_dbg !== 32'h77 || bus.busy_all !== ball_before || bus.busy_all !== exp_busy_all()) begin
      err++; $display("FAIL en0_frozen got dbg=%h ball=%h want 00000077 %h", bus.data_dbg, bus.busy_all, ball_before);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.w0_en   = $urandom_range(0, 1);
      bus.w0_addr = AW'($urandom_range(0, 7));
      bus.w0_data = $urandom;
      bus.w1_en   = $urandom_range(0, 1);
      bus.w1_addr = AW'($urandom_range(0, 7));
      bus.w1_data = $urandom;
      bus.rsv_en  = $urandom_range(0, 1);
      bus.rsv_addr = AW'($urandom_range(0, 7));
      bus.req_rd  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      bus.req_dbg = AW'($urandom_range(0, NREG-1));
      #1;
      for (int p = 0; p < NR; p++) begin
        a = bus.req_rd[p*AW +: AW];
        chk++; if (bus.data_rd[p*DW +: DW] !== exp_data(a) || bus.busy_rd[p] !== exp_busy(a)) begin
          err++; $display("FAIL rand_rd%0d n=%0d a=%0d got %h/%b want %h/%b", p, n, a,
                          bus.data_rd[p*DW +: DW], bus.busy_rd[p], exp_data(a), exp_busy(a));
        end
      end
      chk++; if (bus.data_dbg !== mem[bus.req_dbg] || bus.busy_all !== exp_busy_all()) begin
        err++; $display("FAIL rand_state n=%0d got dbg=%h ball=%h want %h %h", n,
                        bus.data_dbg, bus.busy_all, mem[bus.req_dbg], exp_busy_all());
      end
      cycle();
    end
  endtask

  initial begin
    model_reset();
    idle();
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero();
    test_scoreboard();
    test_en_low();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised multi-port register file for the CPU datapath with the following features:
- configurable data width, register count and number of read ports;
- two write ports;
- write-through bypass on all read ports;
- a per-register scoreboard of pending writes.

It replaces the single-write, two-read register file between decode, which reads and reserves, and writeback, which writes and releases. Decode can detect RAW hazards without a separate hazard table.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count is 2**ADDR_W
- N_RD, 2, number of bypassed read ports (1..4)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; when low no register, scoreboard or write takes effect
- w0_en  input  1  write port 0 enable
- w0_addr  input  ADDR_W  write port 0 address
- w0_data  input  DATA_W  write port 0 data
- w1_en  input  1  write port 1 enable
- w1_addr  input  ADDR_W  write port 1 address
- w1_data  input  DATA_W  write port 1 data
- rsv_en  input  1  reserve request: mark rsv_addr as pending write
- rsv_addr  input  ADDR_W  register to reserve
- req_rd  input  N_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- data_rd  output  N_RD*DATA_W  packed read data, same packing
- busy_rd  output  N_RD  per-port: addressed register has an outstanding reservation
- req_dbg  input  ADDR_W  debug read address
- data_dbg  output  DATA_W  debug read data, committed state only, no bypass
- busy_all  output  2**ADDR_W  full scoreboard vector, bit k = register k pending

## Operation
- Register 0 is hard-wired zero.
  - Writes and reservations to address 0 are ignored.
  - Reads of address 0 return 0 with busy 0.
- Write commit: on a rising edge with en=1, each port with wN_en=1 and wN_addr≠0 stores wN_data.
  - If both ports target the same address, port 1 wins.
- Read port i, combinational, priority high to low:
  1. addr=0 → 0
  2. en & w1_en & w1_addr==addr → w1_data
  3. en & w0_en & w0_addr==addr → w0_data
  4. stored value
- Debug port reads stored value only (0 for address 0).
- Scoreboard, one busy bit per register, updated on the rising edge when en=1:
  - a write on either port to address k clears bit k;
  - rsv_en with rsv_addr=k sets bit k;
  - a set and a clear of the same k in the same cycle → bit ends 1 (the reservation belongs to a later instruction).
- busy_rd[i]:
  - 0 when the addressed register is being written this cycle (bypassed clear);
  - otherwise the stored busy bit.
  - Address 0 → 0.
- Reservation of an already-busy register: bit stays 1. There is no counting; one write releases it.
- en=0 freezes all state. Reads and bypass still evaluate, but bypass is qualified by en, so with en=0 reads return stored values.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0.
  - Consequently data_rd=0, busy_rd=0, data_dbg=0, busy_all=0 while reset is held and after release until the first write.
- Reset asserted mid-cycle clears state immediately, regardless of clk or en.
- Read latency: 0 cycles, combinational from address, write inputs and stored state.
- Write-to-read latency:
  - visible in the same cycle via bypass;
  - visible on the debug port after the rising edge.
- Reserve-to-busy latency: 1 cycle. busy_rd for the reserved address rises after the edge that samples rsv_en.
- Write release: busy clears at the edge of the write. It also reads 0 combinationally in the write cycle itself.

## Test plan
- Reset: preload x5=0x1234, assert rst_n=0 between edges → data_dbg and data_rd for x5 read 0 immediately, busy_all=0.
- Bypass: w0 writes x7=0xAAAA_0001 while req_rd port 0=7 → data_rd port 0=0xAAAA_0001 in the same cycle. After the edge, data_dbg(7)=0xAAAA_0001.
- Dual-write conflict: w0 x9=0x11 and w1 x9=0x22 in the same cycle → read bypass returns 0x22; committed x9=0x22.
- Zero register: w0 x0=0xFFFF_FFFF and rsv x0 → reads of x0 stay 0, busy 0, busy_all[0]=0.
- Scoreboard: reserve x3, next cycle busy_rd=1. Then in one cycle write x3=0x55 and reserve x3 → busy_rd=0 that cycle, data=0x55. Next cycle busy_rd=1.
- en=0: write x4=0x99 with en=0 → no bypass, data_dbg(4) unchanged after the edge, busy_all unchanged.
